arb_req_ctrl: RTL

//  Upstream request stage for the two-way priority arbiter. It accepts burst

---
 rtl/arb_pkg.sv | 19 +
 rtl/arb_req_chan.sv | 98 +++++++++
 rtl/arb_req_ctrl.sv | 51 +++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types and default sizes for the arbiter request stage and its benches.
//   NUM_REQ_DEF  : default number of clients
//   LEN_W_DEF    : default burst length field width
//   TIMEOUT_DEF  : default ungranted cycles before starvation is flagged
//   req_state_t  : per-channel request FSM state
package arb_pkg;

    localparam int unsigned NUM_REQ_DEF = 2;
    localparam int unsigned LEN_W_DEF   = 4;
    localparam int unsigned TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } req_state_t;

endpackage

// File: rtl/arb_req_chan.sv
// One client channel of the arbiter request stage: burst FSM, remaining-beat
// counter and starvation watchdog.
//   clk, rst_n : clock, async active-low reset
//   start      : command strobe, taken only in IDLE with nonzero len
//   len        : burst length in beats
//   grant      : registered grant from the arbiter
//   ready      : channel idle
//   request    : request to the arbiter (REQ/XFER)
//   beat       : one beat transferred this cycle
//   done       : one-cycle completion pulse
//   starve     : sticky, waited TIMEOUT ungranted cycles; cleared by next start
module arb_req_chan
    import arb_pkg::*;
#(
    parameter int unsigned LEN_W   = LEN_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             grant,
    output logic             ready,
    output logic             request,
    output logic             beat,
    output logic             done,
    output logic             starve
);

    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    req_state_t        state_q, state_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [WAIT_W-1:0] wcnt_q, wcnt_d;
    logic              starve_q, starve_d;

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            wcnt_q   <= '0;
            starve_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            wcnt_q   <= wcnt_d;
            starve_q <= starve_d;
        end
    end

    // Next-state, beat counting and watchdog update
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        wcnt_d   = wcnt_q;
        starve_d = starve_q;
        case (state_q)
            IDLE: begin
                if (start && (len != '0)) begin
                    state_d  = REQ;
                    rem_d    = len;
                    wcnt_d   = '0;
                    starve_d = 1'b0;
                end
            end
            REQ, XFER: begin
                if (grant) begin
                    // rem is at least 1 here, so it cannot underflow
                    rem_d   = rem_q - LEN_W'(1);
                    wcnt_d  = '0;
                    state_d = (rem_q == LEN_W'(1)) ? DONE : XFER;
                end else begin
                    if (wcnt_q != WAIT_W'(TIMEOUT)) begin
                        wcnt_d = wcnt_q + WAIT_W'(1);
                    end
                    if (wcnt_d == WAIT_W'(TIMEOUT)) begin
                        starve_d = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state; beat also gated by the live grant
    assign ready   = (state_q == IDLE);
    assign request = (state_q == REQ) || (state_q == XFER);
    assign done    = (state_q == DONE);
    assign beat    = request && grant;
    assign starve  = starve_q;

endmodule

// File: rtl/arb_req_ctrl.sv
// Upstream request stage for the two-way priority arbiter. Holds each client's
// request until its burst has received len granted beats, reports completion
// and flags starvation.
//   clk, rst_n : clock, async active-low reset
//   start      : per-client command strobe (accepted when ready[i])
//   len        : per-client burst length, slice i = len[i*LEN_W +: LEN_W]
//   ready      : client idle
//   request    : arbiter request vector
//   grant      : arbiter grant vector (registered in the arbiter)
//   beat       : beat i transferred this cycle
//   done       : one-cycle burst-complete pulse
//   starve     : sticky starvation flag per client
module arb_req_ctrl
    import arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned LEN_W   = LEN_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       start,
    input  logic [NUM_REQ*LEN_W-1:0] len,
    output logic [NUM_REQ-1:0]       ready,
    output logic [NUM_REQ-1:0]       request,
    input  logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       beat,
    output logic [NUM_REQ-1:0]       done,
    output logic [NUM_REQ-1:0]       starve
);

    // One independent channel per client
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_chan
        arb_req_chan #(
            .LEN_W   (LEN_W),
            .TIMEOUT (TIMEOUT)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .start   (start[i]),
            .len     (len[i*LEN_W +: LEN_W]),
            .grant   (grant[i]),
            .ready   (ready[i]),
            .request (request[i]),
            .beat    (beat[i]),
            .done    (done[i]),
            .starve  (starve[i])
        );
    end

endmodule
